// File: rtl/arc4_pkg.sv
// Shared types and constants for the parametrised ARC4 decryptor.
//   arc4_state_e : top-level phase of a decryption run
//   sub_step_e   : read/wait/swap micro-sequence of the S-box swap engine
package arc4_pkg;

   localparam int unsigned SBOX_SIZE = 256;
   localparam int unsigned MAX_DROP  = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StKsa,
      StLen,
      StDrops,
      StPrga
   } arc4_state_e;

   typedef enum logic [2:0] {
      SubIdle,
      SubWaitI,
      SubRdJ,
      SubWaitJ,
      SubWrI,
      SubWrJ
   } sub_step_e;

endpackage

// File: rtl/arc4_sbox_swap.sv
// S-box swap engine. Owns the S RAM port and performs one
//   rd S[i]; wait; j' = j + S[i] + j_inc; rd S[j']; wait; wr S[i]=S[j']; wr S[j']=S[i]
// sequence per start (6 cycles including the start cycle). While idle and not
// started, the ext_* inputs pass straight through to the RAM port.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a swap (sampled while idle); i/j/j_inc must stay stable
//   i, j, j_inc            swap index, current j, j increment (key byte or 0)
//   ext_addr/wrdata/wren   RAM access used while the engine is idle
//   s_addr/rddata/wrdata/wren  S RAM port
//   si, sj                 old S[i] and S[j'] values from the last swap
//   j_new                  j' from the last swap
//   done                   1 in the final write cycle of a swap
module arc4_sbox_swap
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] i,
   input  logic [7:0] j,
   input  logic [7:0] j_inc,
   input  logic [7:0] ext_addr,
   input  logic [7:0] ext_wrdata,
   input  logic       ext_wren,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] si,
   output logic [7:0] sj,
   output logic [7:0] j_new,
   output logic       done
);

   sub_step_e  step_q, step_d;
   logic [7:0] si_q, sj_q, jn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= SubIdle;
         si_q   <= '0;
         sj_q   <= '0;
         jn_q   <= '0;
      end else begin
         step_q <= step_d;
         if (step_q == SubWaitI) begin
            si_q <= s_rddata;
            jn_q <= j + s_rddata + j_inc;
         end
         if (step_q == SubWaitJ) begin
            sj_q <= s_rddata;
         end
      end
   end

   always_comb begin
      step_d   = step_q;
      s_addr   = ext_addr;
      s_wrdata = ext_wrdata;
      s_wren   = ext_wren;
      done     = 1'b0;
      // Engine owns the port from the start cycle until the last write.
      if (step_q != SubIdle || start) begin
         s_addr   = i;
         s_wrdata = '0;
         s_wren   = 1'b0;
      end
      unique case (step_q)
         SubIdle:  if (start) step_d = SubWaitI;
         SubWaitI: step_d = SubRdJ;
         SubRdJ: begin
            s_addr = jn_q;
            step_d = SubWaitJ;
         end
         SubWaitJ: begin
            s_addr = jn_q;
            step_d = SubWrI;
         end
         SubWrI: begin
            s_wrdata = sj_q;
            s_wren   = 1'b1;
            step_d   = SubWrJ;
         end
         SubWrJ: begin
            // When i == j' both writes carry S[i], leaving S unchanged.
            s_addr   = jn_q;
            s_wrdata = si_q;
            s_wren   = 1'b1;
            done     = 1'b1;
            step_d   = SubIdle;
         end
         default:  step_d = SubIdle;
      endcase
   end

   assign si    = si_q;
   assign sj    = sj_q;
   assign j_new = jn_q;

endmodule

// File: rtl/arc4_decrypt_param.sv
// Parametrised single-core ARC4 decryptor: S-box init, KSA with a KEY_BYTES key
// (big-endian, byte 0 in the MSBs), optional DROP-byte keystream discard, then
// PRGA over a length-prefixed ciphertext held in external 256x8 sync RAMs.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en / rdy       start request / idle indication
//   key            8*KEY_BYTES key, latched on accepted en
//   s_*            S RAM port (via arc4_sbox_swap)
//   ct_addr/rddata CT RAM read port, 1-cycle latency
//   pt_*           PT RAM write port
module arc4_decrypt_param
   import arc4_pkg::*;
#(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned DROP      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             s_addr,
   input  logic [7:0]             s_rddata,
   output logic [7:0]             s_wrdata,
   output logic                   s_wren,
   output logic [7:0]             ct_addr,
   input  logic [7:0]             ct_rddata,
   output logic [7:0]             pt_addr,
   output logic [7:0]             pt_wrdata,
   output logic                   pt_wren
);

   localparam logic [3:0]  KbLast   = 4'(KEY_BYTES - 1);
   localparam logic [10:0] DropLast = 11'((DROP == 0) ? 0 : DROP - 1);
   localparam bit          HasDrop  = (DROP != 0);

   arc4_state_e            state_q, state_d;
   logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
   logic [3:0]             kb_q, kb_d;
   logic [10:0]            drop_q, drop_d;
   logic [1:0]             ph_q, ph_d;  // LEN: 0 wait, 1 capture; PRGA: 0 swap, 1 ks rd, 2 ks use
   logic [8*KEY_BYTES-1:0] key_q;
   logic                   key_load;
   logic [7:0]             key_bytes [16];

   logic       sw_start, sw_done, ext_wren;
   logic [7:0] sw_i, sw_jinc, sw_si, sw_sj, sw_jnew, ext_addr, ext_wrdata;

   for (genvar g = 0; g < 16; g++) begin : g_key
      if (g < KEY_BYTES) begin : g_used
         assign key_bytes[g] = key_q[8*(KEY_BYTES-1-g) +: 8];
      end else begin : g_unused
         assign key_bytes[g] = 8'd0;
      end
   end

   arc4_sbox_swap u_swap (
      .clk        (clk),
      .rst        (rst),
      .start      (sw_start),
      .i          (sw_i),
      .j          (j_q),
      .j_inc      (sw_jinc),
      .ext_addr   (ext_addr),
      .ext_wrdata (ext_wrdata),
      .ext_wren   (ext_wren),
      .s_addr     (s_addr),
      .s_rddata   (s_rddata),
      .s_wrdata   (s_wrdata),
      .s_wren     (s_wren),
      .si         (sw_si),
      .sj         (sw_sj),
      .j_new      (sw_jnew),
      .done       (sw_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         len_q   <= '0;
         kb_q    <= '0;
         drop_q  <= '0;
         ph_q    <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         len_q   <= len_d;
         kb_q    <= kb_d;
         drop_q  <= drop_d;
         ph_q    <= ph_d;
         if (key_load) key_q <= key;
      end
   end

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      len_d      = len_q;
      kb_d       = kb_q;
      drop_d     = drop_q;
      ph_d       = ph_q;
      key_load   = 1'b0;
      rdy        = 1'b0;
      sw_start   = 1'b0;
      sw_i       = i_q;
      sw_jinc    = 8'd0;
      ext_addr   = 8'd0;
      ext_wrdata = 8'd0;
      ext_wren   = 1'b0;
      pt_addr    = 8'd0;
      pt_wrdata  = 8'd0;
      pt_wren    = 1'b0;
      unique case (state_q)
         StIdle: begin
            rdy = 1'b1;
            if (en) begin
               key_load = 1'b1;
               state_d  = StInit;
               i_d      = 8'd0;
               j_d      = 8'd0;
               k_d      = 8'd0;
               kb_d     = 4'd0;
               drop_d   = 11'd0;
               ph_d     = 2'd0;
            end
         end
         StInit: begin
            ext_addr   = i_q;
            ext_wrdata = i_q;
            ext_wren   = 1'b1;
            i_d        = i_q + 8'd1;
            if (i_q == 8'(SBOX_SIZE - 1)) state_d = StKsa;
         end
         StKsa: begin
            sw_start = 1'b1;
            sw_jinc  = key_bytes[kb_q];
            if (sw_done) begin
               j_d  = sw_jnew;
               i_d  = i_q + 8'd1;
               kb_d = (kb_q == KbLast) ? 4'd0 : kb_q + 4'd1;
               if (i_q == 8'(SBOX_SIZE - 1)) begin
                  state_d = StLen;
                  ph_d    = 2'd0;
               end
            end
         end
         StLen: begin
            if (ph_q == 2'd0) begin
               ph_d = 2'd1;
            end else begin
               len_d     = ct_rddata;
               pt_wrdata = ct_rddata;
               pt_wren   = 1'b1;
               i_d       = 8'd0;
               j_d       = 8'd0;
               k_d       = 8'd1;
               ph_d      = 2'd0;
               if (ct_rddata == 8'd0) state_d = StIdle;
               else if (HasDrop)      state_d = StDrops;
               else                   state_d = StPrga;
            end
         end
         StDrops: begin
            sw_i     = i_q + 8'd1;
            sw_start = 1'b1;
            if (sw_done) begin
               i_d    = i_q + 8'd1;
               j_d    = sw_jnew;
               drop_d = drop_q + 11'd1;
               if (drop_q == DropLast) state_d = StPrga;
            end
         end
         StPrga: begin
            sw_i = i_q + 8'd1;
            unique case (ph_q)
               2'd0: begin
                  sw_start = 1'b1;
                  if (sw_done) begin
                     i_d  = i_q + 8'd1;
                     j_d  = sw_jnew;
                     ph_d = 2'd1;
                  end
               end
               2'd1: begin
                  // Post-swap S[i]+S[j] equals the pre-swap pair sum.
                  ext_addr = sw_si + sw_sj;
                  ph_d     = 2'd2;
               end
               default: begin
                  pt_addr   = k_q;
                  pt_wrdata = ct_rddata ^ s_rddata;
                  pt_wren   = 1'b1;
                  k_d       = k_q + 8'd1;
                  ph_d      = 2'd0;
                  if (k_q == len_q) state_d = StIdle;
               end
            endcase
         end
         default: state_d = StIdle;
      endcase
   end

   // ct[k] address is held for the whole byte, so the read overlaps the swap.
   assign ct_addr = (state_q == StPrga) ? k_q : 8'd0;

endmodule

// File: tb/tb_arc4_decrypt_param.sv
// Self-checking bench: four decryptor instances (KEY_BYTES/DROP = 3/0, 4/0, 6/0,
// 3/768), each with its own S, CT and PT RAM models.
module tb_arc4_decrypt_param;

   localparam int NDUT = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NDUT-1:0]  en;
   logic [NDUT-1:0]  rdy;
   logic [127:0]     key [NDUT];
   logic [7:0]       ct_mem [NDUT][256];
   logic [7:0]       ks_ref [256];
   int               n_checks = 0;
   int               n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned KB = (g == 1) ? 4 : (g == 2) ? 6 : 3;
      localparam int unsigned DR = (g == 3) ? 768 : 0;
      logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
      logic       s_wren, pt_wren;
      logic [7:0] s_mem [256];
      logic [7:0] pt_mem [256];
      logic [7:0] pt_last = 8'd0;
      int         pt_wr_cnt = 0;
      int         order_err = 0;

      arc4_decrypt_param #(.KEY_BYTES(KB), .DROP(DR)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en[g]),
         .rdy       (rdy[g]),
         .key       (key[g][8*KB-1:0]),
         .s_addr    (s_addr),
         .s_rddata  (s_rddata),
         .s_wrdata  (s_wrdata),
         .s_wren    (s_wren),
         .ct_addr   (ct_addr),
         .ct_rddata (ct_rddata),
         .pt_addr   (pt_addr),
         .pt_wrdata (pt_wrdata),
         .pt_wren   (pt_wren)
      );

      always @(posedge clk) begin
         s_rddata  <= s_mem[s_addr];
         if (s_wren) s_mem[s_addr] <= s_wrdata;
         ct_rddata <= ct_mem[g][ct_addr];
         if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
            pt_wr_cnt       <= pt_wr_cnt + 1;
            pt_last         <= pt_addr;
            if (pt_addr != 8'd0 && pt_addr != pt_last + 8'd1) order_err <= order_err + 1;
         end
      end
   end

   function automatic int pt_cnt(input int d);
      case (d)
         0:       return g_dut[0].pt_wr_cnt;
         1:       return g_dut[1].pt_wr_cnt;
         2:       return g_dut[2].pt_wr_cnt;
         default: return g_dut[3].pt_wr_cnt;
      endcase
   endfunction

   function automatic logic [7:0] pt_byte(input int d, input int a);
      case (d)
         0:       return g_dut[0].pt_mem[a];
         1:       return g_dut[1].pt_mem[a];
         2:       return g_dut[2].pt_mem[a];
         default: return g_dut[3].pt_mem[a];
      endcase
   endfunction

   function automatic logic [7:0] pt_last_addr(input int d);
      case (d)
         0:       return g_dut[0].pt_last;
         1:       return g_dut[1].pt_last;
         2:       return g_dut[2].pt_last;
         default: return g_dut[3].pt_last;
      endcase
   endfunction

   function automatic int order_errs(input int d);
      case (d)
         0:       return g_dut[0].order_err;
         1:       return g_dut[1].order_err;
         2:       return g_dut[2].order_err;
         default: return g_dut[3].order_err;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Vectors are MSB-first: byte 0 sits in the top 8 of the n used bytes.
   task automatic load_ct(input int d, input logic [127:0] v, input int n);
      for (int k = 0; k < n; k++) ct_mem[d][k] = v[8*(n-1-k) +: 8];
   endtask

   task automatic start_run(input int d, input string tag);
      @(negedge clk);
      en[d] = 1'b1;
      @(negedge clk);
      en[d] = 1'b0;
      check_eq({tag, "_busy"}, 32'(rdy[d]), 32'd0);
   endtask

   task automatic wait_idle(input int d, input int max_cyc, output int cyc);
      cyc = 0;
      while (rdy[d] !== 1'b1 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_vec(input int d, input string tag, input logic [127:0] ctv,
                          input logic [127:0] ptv, input int n);
      int c0, cyc;
      load_ct(d, ctv, n);
      c0 = pt_cnt(d);
      start_run(d, tag);
      wait_idle(d, 4000, cyc);
      check_eq({tag, "_done"}, 32'(rdy[d]), 32'd1);
      check_eq({tag, "_nwr"}, 32'(pt_cnt(d) - c0), 32'(n));
      check_eq({tag, "_last"}, 32'(pt_last_addr(d)), 32'(n - 1));
      for (int k = 0; k < n; k++)
         check_eq($sformatf("%s_pt%0d", tag, k), 32'(pt_byte(d, k)), 32'(ptv[8*(n-1-k) +: 8]));
   endtask

   // Textbook RC4-drop keystream: ks_ref[1..n] are the bytes after the discard.
   task automatic model_ks(input logic [127:0] kv, input int kb, input int drop, input int n);
      logic [7:0] s [256];
      logic [7:0] t, i, j, sum;
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      j = 8'd0;
      for (int a = 0; a < 256; a++) begin
         j    = j + s[a] + kv[8*(kb-1-(a%kb)) +: 8];
         t    = s[a];
         s[a] = s[j];
         s[j] = t;
      end
      i = 8'd0;
      j = 8'd0;
      for (int a = 0; a < drop + n; a++) begin
         i    = i + 8'd1;
         j    = j + s[i];
         t    = s[i];
         s[i] = s[j];
         s[j] = t;
         sum  = s[i] + s[j];
         if (a >= drop) ks_ref[a-drop+1] = s[sum];
      end
   endtask

   localparam logic [127:0] Ct1 = 128'h09BBF316E8D940AF0AD3;
   localparam logic [127:0] Pt1 = 128'h09506C61696E74657874;

   initial begin
      int c0, cyc;
      rst    = 1'b1;
      en     = '0;
      key[0] = 128'h4B6579;
      key[1] = 128'h57696B69;
      key[2] = 128'h536563726574;
      key[3] = 128'h4B6579;
      repeat (3) @(negedge clk);
      check_eq("rst_rdy", 32'(rdy), 32'hF);
      check_eq("rst_wren", {30'd0, g_dut[0].s_wren, g_dut[0].pt_wren}, 32'd0);
      check_eq("rst_addr", {8'd0, g_dut[0].s_addr, g_dut[0].ct_addr, g_dut[0].pt_addr}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Known-answer vectors
      run_vec(0, "key", Ct1, Pt1, 10);
      run_vec(1, "wiki", 128'h051021BF0420, 128'h057065646961, 6);
      run_vec(2, "secret", 128'h0E45A01F645FC35B383552544B9BF5,
              128'h0E41747461636B206174206461776E, 15);

      // Zero-length message
      load_ct(0, 128'h00, 1);
      c0 = pt_cnt(0);
      start_run(0, "l0");
      wait_idle(0, 4000, cyc);
      check_eq("l0_in_time", 32'(cyc <= 1795), 32'd1);
      check_eq("l0_nwr", 32'(pt_cnt(0) - c0), 32'd1);
      check_eq("l0_pt0", 32'(pt_byte(0, 0)), 32'd0);
      check_eq("l0_last", 32'(pt_last_addr(0)), 32'd0);

      // RC4-drop768 over a full 255-byte random message
      ct_mem[3][0] = 8'hFF;
      for (int k = 1; k < 256; k++) ct_mem[3][k] = 8'($urandom);
      model_ks(128'h4B6579, 3, 768, 255);
      c0 = pt_cnt(3);
      start_run(3, "drop");
      wait_idle(3, 12000, cyc);
      check_eq("drop_done", 32'(rdy[3]), 32'd1);
      check_eq("drop_nwr", 32'(pt_cnt(3) - c0), 32'd256);
      check_eq("drop_last", 32'(pt_last_addr(3)), 32'd255);
      check_eq("drop_pt0", 32'(pt_byte(3, 0)), 32'hFF);
      for (int k = 1; k < 256; k++)
         check_eq($sformatf("drop_pt%0d", k), 32'(pt_byte(3, k)), 32'(ct_mem[3][k] ^ ks_ref[k]));

      // en pulsed mid-KSA is ignored
      load_ct(0, Ct1, 10);
      c0 = pt_cnt(0);
      start_run(0, "ign");
      repeat (400) @(negedge clk);
      en[0] = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      wait_idle(0, 4000, cyc);
      repeat (3) @(negedge clk);
      check_eq("ign_idle", 32'(rdy[0]), 32'd1);
      check_eq("ign_nwr", 32'(pt_cnt(0) - c0), 32'd10);
      for (int k = 0; k < 10; k++)
         check_eq($sformatf("ign_pt%0d", k), 32'(pt_byte(0, k)), 32'(Pt1[8*(9-k) +: 8]));

      // en held high: back-to-back runs
      c0 = pt_cnt(0);
      @(negedge clk);
      en[0] = 1'b1;
      @(negedge clk);
      wait_idle(0, 4000, cyc);
      @(negedge clk);
      en[0] = 1'b0;
      check_eq("b2b_restart", 32'(rdy[0]), 32'd0);
      wait_idle(0, 4000, cyc);
      check_eq("b2b_done", 32'(rdy[0]), 32'd1);
      check_eq("b2b_nwr", 32'(pt_cnt(0) - c0), 32'd20);
      check_eq("b2b_pt9", 32'(pt_byte(0, 9)), 32'h74);

      // Reset mid-PRGA aborts cleanly
      c0 = pt_cnt(0);
      start_run(0, "abort");
      cyc = 0;
      while (pt_cnt(0) - c0 < 3 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("abort_in_prga", 32'(pt_cnt(0) - c0), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_rdy", 32'(rdy[0]), 32'd1);
      c0 = pt_cnt(0);
      repeat (30) @(negedge clk);
      check_eq("abort_quiet", 32'(pt_cnt(0) - c0), 32'd0);
      run_vec(0, "rerun", Ct1, Pt1, 10);

      for (int d = 0; d < NDUT; d++)
         check_eq($sformatf("order%0d", d), 32'(order_errs(d)), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
